// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, default widths and limits.
`default_nettype none

package hazard_controller_pkg;

  localparam int REG_AW_DEF      = 5;
  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_controller_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and ID sources.
`default_nettype none

module hazard_detect
  import hazard_controller_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  output logic              load_use
);

  logic dest_valid;
  logic src1_hit;
  logic src2_hit;

  // Register 0 is hardwired, so a load targeting it never produces a dependency.
  assign dest_valid = exe_mem_read & exe_wb_en & (exe_dest != '0);
  assign src1_hit   = (exe_dest == id_src1);
  assign src2_hit   = id_two_src & (exe_dest == id_src2);
  assign load_use   = dest_valid & (src1_hit | src2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush control with memory-wait FSM and timeout.
`default_nettype none

module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              pipe_freeze,
  output logic              mem_timeout,
  output logic [15:0]       stall_cnt
);

  localparam logic [4:0] TIMEOUT_LIM = 5'(MEM_TIMEOUT);

  hz_state_e  state;
  hz_state_e  state_nxt;
  logic [3:0] wait_cnt;
  logic [4:0] wait_inc;
  logic       load_use;
  logic       mem_stall;
  logic       timeout_hit;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall   = mem_req & ~mem_ready;
  assign wait_inc    = {1'b0, wait_cnt} + 5'd1;
  // Trip on the wait cycle that would bring the counter up to the limit.
  assign timeout_hit = (wait_inc >= TIMEOUT_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    // Outputs are gated by reset so nothing leaks out while held in reset.
    if (rst) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pipe_freeze  = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_nxt = RUN;
          end else begin
            pipe_freeze  = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            if (timeout_hit) begin
              state_nxt = ERR;
            end
          end
        end
        ERR: begin
          pipe_freeze  = 1'b1;
          pc_freeze    = 1'b1;
          if_id_freeze = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
    end else if (state != MEM_WAIT) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT && state_nxt == ERR) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (pc_freeze) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller.
`default_nettype none

module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_src;
  logic [4:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_freeze;
  logic        if_id_freeze;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        pipe_freeze;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  int tests_run;
  int tests_failed;

  hazard_controller #(
    .REG_AW     (5),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_freeze   (pc_freeze),
    .if_id_freeze(if_id_freeze),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush (if_id_flush),
    .pipe_freeze (pipe_freeze),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1      = '0;
    id_src2      = '0;
    id_two_src   = 1'b0;
    exe_dest     = '0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pc"},     {31'd0, pc_freeze},    32'd0);
    chk({tag, "_ifid"},   {31'd0, if_id_freeze}, 32'd0);
    chk({tag, "_bubble"}, {31'd0, id_ex_bubble}, 32'd0);
    chk({tag, "_flush"},  {31'd0, if_id_flush},  32'd0);
    chk({tag, "_pipe"},   {31'd0, pipe_freeze},  32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Held in reset with stall-provoking inputs: everything must read 0.
    rst = 1'b0;
    clear_inputs();
    mem_req      = 1'b1;
    branch_taken = 1'b1;
    #2;
    chk_quiet("reset_outputs");
    tick();
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout",   {31'd0, mem_timeout}, 32'd0);
    chk("reset_state",     32'(dut.state), 32'(RUN));
    clear_inputs();
    rst = 1'b1;

    // Load-use on src1 for one cycle.
    exe_mem_read = 1'b1;
    exe_wb_en    = 1'b1;
    exe_dest     = 5'd5;
    id_src1      = 5'd5;
    #1;
    chk("lu_pc",     {31'd0, pc_freeze},    32'd1);
    chk("lu_ifid",   {31'd0, if_id_freeze}, 32'd1);
    chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("lu_flush",  {31'd0, if_id_flush},  32'd0);
    chk("lu_pipe",   {31'd0, pipe_freeze},  32'd0);
    tick();
    exe_dest = 5'd7;
    #1;
    chk("lu_clear_pc",     {31'd0, pc_freeze},    32'd0);
    chk("lu_clear_bubble", {31'd0, id_ex_bubble}, 32'd0);
    chk("lu_stall_cnt",    32'(stall_cnt), 32'd1);

    // Register 0 never hazards.
    exe_dest = 5'd0;
    id_src1  = 5'd0;
    #1;
    chk_quiet("r0");

    // src2 match ignored when the instruction has only one source.
    exe_dest   = 5'd5;
    id_src1    = 5'd3;
    id_src2    = 5'd5;
    id_two_src = 1'b0;
    #1;
    chk_quiet("src2_unused");

    // Same src2 match counts once the instruction reads src2.
    id_two_src = 1'b1;
    #1;
    chk("src2_pc",     {31'd0, pc_freeze},    32'd1);
    chk("src2_bubble", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    chk("src2_stall_cnt", 32'(stall_cnt), 32'd2);

    // No hazard when EX is not a load.
    exe_mem_read = 1'b0;
    #1;
    chk_quiet("not_load");

    // Branch flush wins over load-use.
    exe_mem_read = 1'b1;
    id_two_src   = 1'b0;
    id_src1      = 5'd5;
    branch_taken = 1'b1;
    #1;
    chk("br_flush",  {31'd0, if_id_flush},  32'd1);
    chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("br_pc",     {31'd0, pc_freeze},    32'd0);
    chk("br_ifid",   {31'd0, if_id_freeze}, 32'd0);
    tick();
    chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

    // Memory request completing immediately causes no stall.
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk_quiet("mem_fast");
    tick();
    chk("mem_fast_state", 32'(dut.state), 32'(RUN));

    // Four freeze cycles (one in RUN, three in MEM_WAIT), then ready.
    mem_ready    = 1'b0;
    branch_taken = 1'b1;
    #1;
    chk("stall_flush_suppressed",  {31'd0, if_id_flush},  32'd0);
    chk("stall_bubble_suppressed", {31'd0, id_ex_bubble}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_pipe_%0d", i), {31'd0, pipe_freeze}, 32'd1);
      chk($sformatf("stall_pc_%0d", i),   {31'd0, pc_freeze},   32'd1);
      tick();
      branch_taken = 1'b0;
      #1;
      chk($sformatf("stall_state_%0d", i), 32'(dut.state), 32'(MEM_WAIT));
    end
    mem_ready = 1'b1;
    #1;
    chk("ready_pipe", {31'd0, pipe_freeze}, 32'd0);
    chk("ready_pc",   {31'd0, pc_freeze},   32'd0);
    tick();
    mem_req = 1'b0;
    chk("ready_state",     32'(dut.state), 32'(RUN));
    chk("ready_stall_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: 15 MEM_WAIT cycles then ERR.
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("wait_state_%0d", i),   32'(dut.state), 32'(MEM_WAIT));
      chk($sformatf("wait_timeout_%0d", i), {31'd0, mem_timeout}, 32'd0);
      tick();
    end
    chk("err_state",     32'(dut.state), 32'(ERR));
    chk("err_timeout",   {31'd0, mem_timeout}, 32'd1);
    chk("err_pc",        {31'd0, pc_freeze},   32'd1);
    chk("err_pipe",      {31'd0, pipe_freeze}, 32'd1);
    chk("err_stall_cnt", 32'(stall_cnt), 32'd16);
    mem_req   = 1'b0;
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("err_sticky_state",   32'(dut.state), 32'(ERR));
    chk("err_sticky_timeout", {31'd0, mem_timeout}, 32'd1);
    chk("err_sticky_ifid",    {31'd0, if_id_freeze}, 32'd1);

    // Long ERR stall drives the counter into saturation.
    repeat (65530) @(posedge clk);
    #1;
    chk("sat_reach", 32'(stall_cnt), 32'h0000FFFF);
    repeat (5) tick();
    chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);

    // Asynchronous reset mid-ERR.
    rst = 1'b0;
    #1;
    chk_quiet("err_rst");
    chk("err_rst_state",     32'(dut.state), 32'(RUN));
    chk("err_rst_timeout",   {31'd0, mem_timeout}, 32'd0);
    chk("err_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_pc",    {31'd0, pc_freeze},   32'd0);
    chk("post_rst_pipe",  {31'd0, pipe_freeze}, 32'd0);
    chk("post_rst_state", 32'(dut.state), 32'(RUN));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
